// File: rtl/pwm_multichannel_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multichannel_if
//  Purpose  : Bundles the configuration, duty-write bus and PWM outputs of
//             pwm_multichannel into one interface.
//  Modports : master - register bank side (drives config/writes, sees outputs)
//             slave  - PWM generator side
//  Signals  : en_out, en_pwm, polarity  per-channel enables / invert
//             period, prescale          counter top value / clock divider
//             duty_wr_en/ch/data        single-cycle duty write strobe
//             out, period_tick          registered PWM outputs, wrap pulse
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_multichannel_if #(
    parameter int NUM_CH     = 16,
    parameter int CNT_W      = 8,
    parameter int PRESCALE_W = 12
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]     en_out;
    logic [NUM_CH-1:0]     en_pwm;
    logic [NUM_CH-1:0]     polarity;
    logic [CNT_W-1:0]      period;
    logic [PRESCALE_W-1:0] prescale;
    logic                  duty_wr_en;
    logic [CH_W-1:0]       duty_wr_ch;
    logic [CNT_W-1:0]      duty_wr_data;
    logic [NUM_CH-1:0]     out;
    logic                  period_tick;

    modport master (
        output en_out,
        output en_pwm,
        output polarity,
        output period,
        output prescale,
        output duty_wr_en,
        output duty_wr_ch,
        output duty_wr_data,
        input  out,
        input  period_tick
    );

    modport slave (
        input  en_out,
        input  en_pwm,
        input  polarity,
        input  period,
        input  prescale,
        input  duty_wr_en,
        input  duty_wr_ch,
        input  duty_wr_data,
        output out,
        output period_tick
    );
endinterface
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multichannel
//  Purpose  : Parametrised N-channel PWM generator with per-channel duty,
//             programmable period and prescaler, per-channel polarity and
//             glitch-free shadowed duty/period updates at period boundaries.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - pwm_multichannel_if.slave (config, duty writes, outputs)
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multichannel #(
    parameter int NUM_CH     = 16,
    parameter int CNT_W      = 8,
    parameter int PRESCALE_W = 12
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pwm_multichannel_if.slave   bus
);
    localparam int CH_W = $clog2(NUM_CH);
    // One extra bit so that channel indices at or above NUM_CH are
    // representable in the range check for non-power-of-two channel counts.
    localparam logic [CH_W:0] c_num_ch = (CH_W+1)'(NUM_CH);

    // ------------------------------------------------------------------
    // Shared timebase
    // ------------------------------------------------------------------
    logic                  r_load_first;
    logic [PRESCALE_W-1:0] r_presc;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_active_period;
    logic [NUM_CH-1:0]     r_out;
    logic                  r_period_tick;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_load;
    logic                  w_wr_ok;
    logic [NUM_CH-1:0]     w_raw;

    // The first edge after reset is reserved for loading the shadow
    // registers, so neither the prescaler nor the counter moves in it.
    assign w_tick  = ~r_load_first & (r_presc == bus.prescale);
    assign w_wrap  = w_tick & (r_cnt == r_active_period);
    assign w_load  = r_load_first | w_wrap;
    assign w_wr_ok = bus.duty_wr_en & ({1'b0, bus.duty_wr_ch} < c_num_ch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_first <= 1'b1;
        end else begin
            r_load_first <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (r_load_first || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_load_first || w_wrap) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_period <= '0;
        end else if (w_load) begin
            r_active_period <= bus.period;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel duty shadowing and compare
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_pend_duty;
        logic [CNT_W-1:0] r_active_duty;
        logic             w_wr_sel;

        assign w_wr_sel = w_wr_ok & (bus.duty_wr_ch == CH_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pend_duty <= '0;
            end else if (w_wr_sel) begin
                r_pend_duty <= bus.duty_wr_data;
            end
        end

        // A write landing on the same edge as a load goes straight into
        // the active duty so it is not lost for a whole period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_active_duty <= '0;
            end else if (w_load) begin
                r_active_duty <= w_wr_sel ? bus.duty_wr_data : r_pend_duty;
            end
        end

        // Counter never exceeds the active period, so a duty above the
        // period yields a constant high and duty zero a constant low.
        assign w_raw[i] = bus.en_pwm[i] ? (r_cnt < r_active_duty) : 1'b1;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out         <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_out         <= bus.en_out & (w_raw ^ bus.polarity);
            r_period_tick <= w_wrap;
        end
    end

    assign bus.out         = r_out;
    assign bus.period_tick = r_period_tick;

endmodule
`default_nettype wire
